health_ctrl: RTL and testbench
==============================

Name: health_ctrl

Overview:
- Parametrised player-health controller for the game logic layer; successor to the single-source health counter.
- Accepts damage from N_SRC independent sources (slimes, hazards, projectiles) and a heal request; keeps health within [0, HP_MAX].
- Runs an invulnerability window after each hit, timed in ticks of an external timebase, and latches a death state.
- Feeds the HUD heart display, sprite flicker and game-over logic.

Parameters:
- HP_W, 4, width of the health value.
- HP_MAX, 5, maximum health; heal saturates here (must be < 2^HP_W).
- HP_INIT, 3, health loaded at reset (1..HP_MAX).
- N_SRC, 2, number of damage source channels.
- DMG_W, 2, width of each per-source damage amount.
- INV_TICKS, 15, length of the invulnerability window in tick pulses (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; restores HP_INIT and the ALIVE state.
- tick  in  1  one-cycle timebase enable pulse from the frame/prescaler counter.
- dmg_valid  in  N_SRC  per-source hit request, sampled every cycle.
- dmg_amt  in  N_SRC*DMG_W  per-source damage; source i uses bits [i*DMG_W +: DMG_W].
- heal  in  1  heal request, sampled every cycle.
- heal_amt  in  HP_W  heal amount.
- health  out  HP_W  current health.
- invuln  out  1  high while in the INVULN state.
- blink  out  1  sprite flicker enable; toggles on each tick while INVULN, 0 otherwise.
- hit  out  1  one-cycle pulse on the cycle after damage is applied.
- dead  out  1  high in the DEAD state.

Behaviour:
- Clock and reset: reset is synchronous, active-high, clock clk. All outputs are registered. Inputs sampled in cycle N take effect on the outputs in cycle N+1.
- Reset values: health=HP_INIT, invuln=0, blink=0, hit=0, dead=0, inv_cnt=0, state=ALIVE. Reset takes priority over every other event in the same cycle, including mid-window and in DEAD.
- Damage sum: D = sum of dmg_amt[i] over all i with dmg_valid[i]=1. The sum is computed at width DMG_W+clog2(N_SRC) so it never overflows. A valid source with amount 0 contributes 0.
- An effective hit requires state ALIVE and D>0.

State ALIVE:
- Effective hit: health <= max(health-D, 0); hit=1 for one cycle. The heal request in the same cycle is discarded (damage has priority).
  - If the new health is 0: go to DEAD.
  - Otherwise: go to INVULN with inv_cnt=0 and blink=1.
- Heal with no effective hit: health <= min(health+heal_amt, HP_MAX). Computed at HP_W+1 bits, so there is no wrap.

State INVULN:
- All dmg_valid inputs are ignored and hit stays 0. Heal is applied as in ALIVE.
- Each cycle with tick=1: inv_cnt increments and blink toggles.
- When inv_cnt reaches INV_TICKS-1 and tick=1: go to ALIVE, clear invuln and blink, set inv_cnt=0.
- A tick in the same cycle as the entering hit does not count; counting starts the cycle after entry.

State DEAD:
- health=0, dead=1. Damage and heal are ignored; only reset exits.

Boundaries:
- Health already at HP_MAX: heal leaves it unchanged.
- D greater than health: clamp to 0, then DEAD.
- Simultaneous hits from several sources in one cycle are summed into one hit: a single hit pulse and a single window.
- tick has no effect in ALIVE or DEAD.

Outputs by state: invuln=(state==INVULN), dead=(state==DEAD).

Test Plan:
- Reset check: assert reset 2 cycles -> health=3, invuln=0, dead=0, hit=0.
- Single hit and window: dmg_valid=01, amt0=1 for 1 cycle -> next cycle health=2, hit pulse 1 cycle, invuln=1. Send 14 ticks -> still invuln, blink toggled 14 times. 15th tick -> invuln=0 next cycle.
- Immunity: during the window, dmg_valid=11 with amounts 3/3 -> health stays 2, no hit pulse.
- Simultaneous sources and death: from health=3, ALIVE, dmg_valid=11, amt0=2, amt1=2 -> health=0, dead=1, one hit pulse. Later heal=1, heal_amt=5 -> health stays 0.
- Heal saturation and priority: health=3, heal_amt=4 -> health=5. Then a heal (amt 2) together with a hit of amt 1 in the same cycle -> health=4, INVULN.
- Reset mid-window: reset asserted while invuln=1, inv_cnt=7 -> health=3, invuln=0, blink=0. A hit is accepted immediately after reset.

Source files
------------

// File: rtl/health_ctrl.sv
// Player health controller: sums damage from N_SRC sources, applies heals, and runs
// a tick-timed invulnerability window after each hit; latches DEAD until reset.
module health_ctrl #(
    parameter int HP_W      = 4,
    parameter int HP_MAX    = 5,
    parameter int HP_INIT   = 3,
    parameter int N_SRC     = 2,
    parameter int DMG_W     = 2,
    parameter int INV_TICKS = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [N_SRC-1:0]       dmg_valid,
    input  logic [N_SRC*DMG_W-1:0] dmg_amt,
    input  logic                   heal,
    input  logic [HP_W-1:0]        heal_amt,
    output logic [HP_W-1:0]        health,
    output logic                   invuln,
    output logic                   blink,
    output logic                   hit,
    output logic                   dead
);

    localparam int SUM_W = DMG_W + $clog2(N_SRC);
    localparam int CMP_W = (HP_W > SUM_W) ? HP_W : SUM_W;
    localparam int CNT_W = (INV_TICKS > 1) ? $clog2(INV_TICKS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INV_TICKS - 1);
    localparam logic [HP_W:0]    HP_MAX_X = (HP_W + 1)'(HP_MAX);
    localparam logic [HP_W-1:0]  HP_MAX_V = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]  HP_INIT_V = HP_W'(HP_INIT);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] inv_cnt;

    logic [SUM_W-1:0] dmg_sum;
    logic [CMP_W-1:0] health_x;
    logic [CMP_W-1:0] dmg_x;
    logic             lethal;
    logic [HP_W-1:0]  health_after_dmg;
    logic [HP_W:0]    heal_sum;
    logic [HP_W-1:0]  health_after_heal;

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        dmg_sum = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (dmg_valid[i]) begin
                dmg_sum = dmg_sum + SUM_W'(dmg_amt[i*DMG_W +: DMG_W]);
            end
        end
    end

    // Damage and heal are evaluated at widths wide enough that neither can wrap.
    always_comb begin
        health_x         = CMP_W'(health);
        dmg_x            = CMP_W'(dmg_sum);
        lethal           = (dmg_x >= health_x);
        health_after_dmg = lethal ? '0 : HP_W'(health_x - dmg_x);

        heal_sum          = {1'b0, health} + {1'b0, heal_amt};
        health_after_heal = (heal_sum > HP_MAX_X) ? HP_MAX_V : heal_sum[HP_W-1:0];
    end

    // NOTE: all state and output registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ALIVE;
            health  <= HP_INIT_V;
            inv_cnt <= '0;
            invuln  <= 1'b0;
            blink   <= 1'b0;
            hit     <= 1'b0;
            dead    <= 1'b0;
        end else begin
            hit <= 1'b0;
            case (state)
                ALIVE: begin
                    if (dmg_sum != '0) begin
                        hit    <= 1'b1;
                        health <= health_after_dmg;
                        if (lethal) begin
                            state <= DEAD;
                            dead  <= 1'b1;
                        end else begin
                            state   <= INVULN;
                            invuln  <= 1'b1;
                            blink   <= 1'b1;
                            inv_cnt <= '0;
                        end
                    end else if (heal) begin
                        health <= health_after_heal;
                    end
                end

                INVULN: begin
                    if (heal) begin
                        health <= health_after_heal;
                    end
                    if (tick) begin
                        if (inv_cnt == CNT_LAST) begin
                            state   <= ALIVE;
                            invuln  <= 1'b0;
                            blink   <= 1'b0;
                            inv_cnt <= '0;
                        end else begin
                            inv_cnt <= inv_cnt + 1'b1;
                            blink   <= ~blink;
                        end
                    end
                end

                DEAD: begin
                    health <= '0;
                    dead   <= 1'b1;
                end

                default: begin
                    state  <= ALIVE;
                    invuln <= 1'b0;
                    blink  <= 1'b0;
                    dead   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_health_ctrl.sv
// Self-checking bench for health_ctrl: a table of single-cycle vectors plus hand-written
// sequences for the invulnerability window and reset mid-window.
module tb_health_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] dmg_valid;
    logic [3:0] dmg_amt;
    logic       heal;
    logic [3:0] heal_amt;
    logic [3:0] health;
    logic       invuln;
    logic       blink;
    logic       hit;
    logic       dead;

    int errors = 0;
    int checks = 0;

    health_ctrl #(
        .HP_W(4), .HP_MAX(5), .HP_INIT(3), .N_SRC(2), .DMG_W(2), .INV_TICKS(15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .dmg_valid (dmg_valid),
        .dmg_amt   (dmg_amt),
        .heal      (heal),
        .heal_amt  (heal_amt),
        .health    (health),
        .invuln    (invuln),
        .blink     (blink),
        .hit       (hit),
        .dead      (dead)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       tck;
        logic [1:0] valid;
        logic [3:0] amt;     // {amt1, amt0}
        logic       hl;
        logic [3:0] hamt;
        logic [3:0] e_health;
        logic       e_inv;
        logic       e_blink;
        logic       e_hit;
        logic       e_dead;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic rst, input logic tck, input logic [1:0] valid,
                        input logic [3:0] amt, input logic hl, input logic [3:0] hamt);
        @(negedge clk);
        reset     = rst;
        tick      = tck;
        dmg_valid = valid;
        dmg_amt   = amt;
        heal      = hl;
        heal_amt  = hamt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eh, input logic ei,
                              input logic eb, input logic ehit, input logic ed);
        check({tag, ".health"}, 32'(health), 32'(eh));
        check({tag, ".invuln"}, 32'(invuln), 32'(ei));
        check({tag, ".blink"},  32'(blink),  32'(eb));
        check({tag, ".hit"},    32'(hit),    32'(ehit));
        check({tag, ".dead"},   32'(dead),   32'(ed));
    endtask

    initial begin
        reset     = 1'b1;
        tick      = 1'b0;
        dmg_valid = '0;
        dmg_amt   = '0;
        heal      = 1'b0;
        heal_amt  = '0;

        //               rst tck valid  amt      hl  hamt   health inv blk hit dead
        vecs.push_back('{1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 4'd2, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 4'b0001, 1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2'b11, 4'b1111, 1'b0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2'b11, 4'b1010, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 4'b0011, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 4'b1100, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2'b10, 4'b1100, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 4'b1111, 1'b1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].tck, vecs[i].valid, vecs[i].amt, vecs[i].hl, vecs[i].hamt);
            check_outs($sformatf("vec%0d", i), vecs[i].e_health, vecs[i].e_inv,
                       vecs[i].e_blink, vecs[i].e_hit, vecs[i].e_dead);
        end

        // Full window: the tick coinciding with the entering hit must not count.
        step(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 4'd0);
        check_outs("win.reset", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b01, 4'b0001, 1'b0, 4'd0);
        check_outs("win.enter", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            if (k == 1) step(1'b0, 1'b1, 2'b11, 4'b1111, 1'b0, 4'd0);
            else        step(1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 4'd0);
            check_outs($sformatf("win.tick%0d", k), 4'd2, 1'b1, (k % 2 == 0), 1'b0, 1'b0);
            step(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 4'd0);
            check_outs($sformatf("win.gap%0d", k), 4'd2, 1'b1, (k % 2 == 0), 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 4'd0);
        check_outs("win.exit", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 4'd0);
        check_outs("win.alive_tick", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'b01, 4'b0001, 1'b0, 4'd0);
        check_outs("win.rehit", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a window, then an immediate hit.
        step(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 4'd0);
        step(1'b0, 1'b0, 2'b01, 4'b0001, 1'b0, 4'd0);
        check_outs("mid.enter", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 4'd0);
        end
        check_outs("mid.cnt7", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'b00, 4'b0000, 1'b0, 4'd0);
        check_outs("mid.reset", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'b01, 4'b0010, 1'b0, 4'd0);
        check_outs("mid.hit", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 4'd0);
        check_outs("mid.after", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
